uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised next-generation UART receiver for the serial bus UART path. Supports configurable data width, oversampling ratio, optional parity and one or two stop bits. Adds input synchronisation, 3-sample majority voting, false-start rejection, and parity/framing/overrun/break reporting. Sits between the raw Rx pin and the bus-side UART adapter. Uses the same ready/ready_clr handshake as the existing receiver.

Parameters:
DATA_BITS, 8, payload bits per frame, 5..9, LSB first
OVERSAMPLE, 16, clken ticks per bit; even, >=4
PARITY_EN, 0, 1 = one parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored if PARITY_EN=0
STOP_BITS, 1, 1 or 2

Ports:
clk_50m  in  1  system clock
rstn  in  1  asynchronous active-low reset
clken  in  1  oversample tick, one clk_50m cycle wide
Rx  in  1  asynchronous serial input, idle high
ready_clr  in  1  clears ready and overrun
ready  out  1  frame available
data  out  DATA_BITS  last received payload
parity_err  out  1  parity mismatch on last frame
frame_err  out  1  a stop bit sampled low on last frame
break_det  out  1  last frame all-zero payload with frame_err
overrun  out  1  frame completed while ready was still 1

Behaviour:
- Reset (rstn=0, async): all outputs 0; synchroniser flops = 1; state IDLE; counters 0.
- Rx passes through a 2-flop synchroniser on clk_50m, not gated by clken. All logic below uses the synchronised value rxs. State and counters advance only on cycles with clken=1.
- Let MID = OVERSAMPLE/2. The sample counter is $clog2(OVERSAMPLE) bits, runs 0..OVERSAMPLE-1, then wraps to 0 and advances the bit.
- Majority vote: rxs is captured at counts MID-1, MID and MID+1. The bit value is the majority of the three, decided at count MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxs=0 at a clken, go to START with the counter at 1.
- START: at the MID+1 decision, a majority of 1 is a false start: return to IDLE with no flags changed. Otherwise continue; at counter wrap go to DATA with bit index 0.
- DATA: the voted bit is written to scratch[index]. After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: compute the XOR of the payload and the parity bit. Error = (XOR != PARITY_ODD).
- STOP: vote each stop bit. Any stop bit voted 0 sets the frame error.
- Completion happens at the MID+1 decision of the last stop bit, not at its wrap, which allows resync on the next start edge. On that clken cycle:
  - data <= scratch
  - parity_err, frame_err and break_det are loaded for this frame
  - ready <= 1
  - state returns to IDLE
  - outputs are visible the next clk_50m cycle
- Overrun: if ready=1 and ready_clr=0 at completion, overrun <= 1 (sticky) and data/flags are overwritten with the new frame.
- ready_clr (any cycle, not gated by clken): ready <= 0 and overrun <= 0.
- Simultaneous ready_clr and completion: completion wins. ready=1, overrun unchanged, no overrun set.
- Error flags hold their values until the next completion; they are not cleared by ready_clr.
- A frame with frame_err still asserts ready, and data carries the received payload.
- Rx glitch shorter than the vote window in IDLE: rejected as a false start; ready is not asserted.
- rstn asserted mid-frame: immediate return to reset values; the partial frame is discarded.
- Latency: Rx falling edge to ready ≈ 2 clk + (1 + DATA_BITS + PARITY_EN + STOP_BITS - 0.5) × OVERSAMPLE clken ticks.

Test Plan:
- Defaults, clken every 27 clk (≈115200 baud × 16). Send 0xA5 with 1 stop -> ready=1, data=0xA5, all flags 0. ready_clr -> ready=0.
- PARITY_EN=1, PARITY_ODD=0. Send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1, data=0x07, ready=1.
- Send 0x3C and 0x81 back-to-back without ready_clr -> data=0x81, overrun=1. Then ready_clr -> overrun=0, ready=0. Repeat with ready_clr on the completion cycle -> ready=1, overrun=0.
- Rx low for 4 clken ticks in IDLE -> state returns to IDLE, ready stays 0. Then a single-tick 1-glitch at count MID inside data bit 3 of 0x00 -> data=0x00 (majority vote).
- Hold Rx low for 12 bit times -> ready=1, data=0x00, frame_err=1, break_det=1. STOP_BITS=2 with second stop bit low -> frame_err=1, break_det=0 for payload 0x55.
- Assert rstn=0 during data bit 4 -> all outputs 0 immediately. Next clean frame 0x5A -> received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : Oversampling UART receiver with a 2-flop input synchroniser,
//                3-sample majority vote, false-start rejection, optional
//                parity, 1 or 2 stop bits, and parity / framing / break /
//                overrun reporting behind a ready / ready_clr handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50m,
    input  logic                 rstn,
    input  logic                 clken,
    input  logic                 Rx,
    input  logic                 ready_clr,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int                 c_cnt_w    = $clog2(OVERSAMPLE);
    localparam int                 c_mid      = OVERSAMPLE / 2;
    localparam int                 c_idx_w    = 4;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_cnt_w-1:0] c_vote0    = c_cnt_w'(c_mid - 1);
    localparam logic [c_cnt_w-1:0] c_vote1    = c_cnt_w'(c_mid);
    localparam logic [c_cnt_w-1:0] c_vote2    = c_cnt_w'(c_mid + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);
    localparam logic               c_par_en   = (PARITY_EN != 0);
    localparam logic               c_par_odd  = (PARITY_ODD != 0);
    localparam logic               c_stop_last = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Synchroniser
    logic rx_meta_q, rx_meta_d;
    logic rxs_q, rxs_d;

    // Frame engine
    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [c_idx_w-1:0]   bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 vote_a_q, vote_a_d;
    logic                 vote_b_q, vote_b_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;

    // Output registers
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q, break_d;
    logic                 overrun_q, overrun_d;

    logic                 w_vote;
    logic                 w_decide;
    logic                 w_wrap;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_complete;
    logic                 w_frame_err;

    assign rx_meta_d   = Rx;
    assign rxs_d       = rx_meta_q;
    assign w_vote      = (vote_a_q & vote_b_q) | (vote_a_q & rxs_q) | (vote_b_q & rxs_q);
    assign w_decide    = (cnt_q == c_vote2);
    assign w_wrap      = (cnt_q == c_cnt_last);
    assign w_cnt_inc   = w_wrap ? '0 : cnt_q + c_cnt_one;
    assign w_frame_err = ferr_pend_q | ~w_vote;

    // Register all state; synchroniser resets to the idle-high line level
    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            scratch_q    <= '0;
            vote_a_q     <= 1'b0;
            vote_b_q     <= 1'b0;
            perr_pend_q  <= 1'b0;
            ferr_pend_q  <= 1'b0;
            data_q       <= '0;
            ready_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            scratch_q    <= scratch_d;
            vote_a_q     <= vote_a_d;
            vote_b_q     <= vote_b_d;
            perr_pend_q  <= perr_pend_d;
            ferr_pend_q  <= ferr_pend_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame FSM: sample counting, voting, bit assembly and completion detect
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        scratch_d   = scratch_q;
        vote_a_d    = vote_a_q;
        vote_b_d    = vote_b_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        w_complete  = 1'b0;

        if (clken) begin
            if (cnt_q == c_vote0) vote_a_d = rxs_q;
            if (cnt_q == c_vote1) vote_b_d = rxs_q;

            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        // The detecting tick counts as sample 0 of the start bit
                        state_d     = S_START;
                        cnt_d       = c_cnt_one;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                    end
                end
                S_START: begin
                    cnt_d = w_cnt_inc;
                    if (w_decide && w_vote) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (w_wrap) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
                S_DATA: begin
                    cnt_d = w_cnt_inc;
                    if (w_decide) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bit_idx_q == c_idx_w'(i)) scratch_d[i] = w_vote;
                        end
                    end
                    if (w_wrap) begin
                        if (bit_idx_q == c_idx_last) begin
                            state_d    = c_par_en ? S_PARITY : S_STOP;
                            stop_idx_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx_q + c_idx_w'(1);
                        end
                    end
                end
                S_PARITY: begin
                    cnt_d = w_cnt_inc;
                    if (w_decide) perr_pend_d = ((^scratch_q) ^ w_vote) != c_par_odd;
                    if (w_wrap) begin
                        state_d    = S_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
                S_STOP: begin
                    cnt_d = w_cnt_inc;
                    if (w_decide) begin
                        ferr_pend_d = w_frame_err;
                        // Finish mid-bit on the last stop so the next start edge is caught
                        if (stop_idx_q == c_stop_last) begin
                            w_complete = 1'b1;
                            state_d    = S_IDLE;
                            cnt_d      = '0;
                        end
                    end else if (w_wrap) begin
                        stop_idx_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output bank: completion loads the frame and wins over a same-cycle clear
    always_comb begin
        data_d       = data_q;
        ready_d      = ready_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_d      = break_q;
        overrun_d    = overrun_q;

        if (w_complete) begin
            data_d       = scratch_q;
            parity_err_d = perr_pend_q;
            frame_err_d  = w_frame_err;
            break_d      = (scratch_q == '0) && w_frame_err;
            ready_d      = 1'b1;
            if (ready_q && !ready_clr) overrun_d = 1'b1;
        end else if (ready_clr) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign ready      = ready_q;
    assign data       = data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame
//  Description : Self-checking bench for uart_rx_frame: default, parity and
//                two-stop-bit instances share one serial line; expected frames
//                are queued when driven and compared when each completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int c_os = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ready;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] payload;
        int         bad_stop;
        exp_t       exp;
    } vec_t;

    logic       clk_50m = 1'b0;
    logic       rstn    = 1'b0;
    logic       clken   = 1'b0;
    logic       rx      = 1'b1;
    logic       ready_clr = 1'b0;
    int         div_cnt = 0;

    logic [2:0] rdy, perr, ferr, brk, ovr;
    logic [7:0] dat [3];

    int   sel     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q [$];
    vec_t vecs [3];

    always #10 clk_50m = ~clk_50m;

    // Oversample tick: one clk wide, every 27 clocks
    always @(posedge clk_50m) begin
        if (div_cnt == 26) begin
            div_cnt <= 0;
            clken   <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            clken   <= 1'b0;
        end
    end

    uart_rx_frame u_dut (
        .clk_50m(clk_50m), .rstn(rstn), .clken(clken), .Rx(rx), .ready_clr(ready_clr),
        .ready(rdy[0]), .data(dat[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
        .break_det(brk[0]), .overrun(ovr[0])
    );

    uart_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk_50m(clk_50m), .rstn(rstn), .clken(clken), .Rx(rx), .ready_clr(ready_clr),
        .ready(rdy[1]), .data(dat[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
        .break_det(brk[1]), .overrun(ovr[1])
    );

    uart_rx_frame #(.STOP_BITS(2)) u_st2 (
        .clk_50m(clk_50m), .rstn(rstn), .clken(clken), .Rx(rx), .ready_clr(ready_clr),
        .ready(rdy[2]), .data(dat[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
        .break_det(brk[2]), .overrun(ovr[2])
    );

    function automatic exp_t mk(input logic [7:0] d, input logic r, input logic p,
                                input logic f, input logic b, input logic o);
        exp_t e;
        e.data = d; e.ready = r; e.perr = p; e.ferr = f; e.brk = b; e.ovr = o;
        return e;
    endfunction

    function automatic exp_t observed(input int s);
        return mk(dat[s], rdy[s], perr[s], ferr[s], brk[s], ovr[s]);
    endfunction

    task automatic check_rec(input string name, input exp_t e);
        exp_t g;
        g = observed(sel);
        n_total++;
        if (g !== e)
            $display("FAIL %s: got data=%h rdy=%b perr=%b ferr=%b brk=%b ovr=%b, expected data=%h rdy=%b perr=%b ferr=%b brk=%b ovr=%b",
                     name, g.data, g.ready, g.perr, g.ferr, g.brk, g.ovr,
                     e.data, e.ready, e.perr, e.ferr, e.brk, e.ovr);
        else
            n_pass++;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %b, expected %b", name, got, exp);
        else n_pass++;
    endtask

    task automatic sb_check(input string name);
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: frame completed with empty scoreboard, got data=%h", name, dat[sel]);
        end else begin
            n_total--;
            check_rec(name, sb_q.pop_front());
        end
    endtask

    // Returns just after the next clock edge on which clken was sampled high
    task automatic wait_tick();
        do @(negedge clk_50m); while (clken !== 1'b1);
        @(posedge clk_50m);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk_50m);
        ready_clr = 1'b1;
        @(negedge clk_50m);
        ready_clr = 1'b0;
    endtask

    task automatic reset_all();
        rx        = 1'b1;
        ready_clr = 1'b0;
        rstn      = 1'b0;
        repeat (3) @(negedge clk_50m);
        rstn = 1'b1;
        repeat (2) wait_tick();
    endtask

    task automatic send_frame(input string name, input logic [7:0] payload,
                              input bit has_par, input logic par_bit, input int nstop,
                              input int bad_stop, input int glitch_bit, input bit clr_at_end);
        wait_tick();
        rx = 1'b0;
        repeat (c_os) wait_tick();
        for (int i = 0; i < 8; i++) begin
            rx = payload[i];
            if (i == glitch_bit) begin
                repeat (8) wait_tick();
                rx = ~payload[i];
                wait_tick();
                rx = payload[i];
                repeat (7) wait_tick();
            end else begin
                repeat (c_os) wait_tick();
            end
        end
        if (has_par) begin
            rx = par_bit;
            repeat (c_os) wait_tick();
        end
        for (int s = 0; s < nstop; s++) begin
            rx = (s == bad_stop) ? 1'b0 : 1'b1;
            if (s == nstop - 1) begin
                if (clr_at_end) begin
                    repeat (9) wait_tick();
                    do @(negedge clk_50m); while (clken !== 1'b1);
                    ready_clr = 1'b1;
                    @(posedge clk_50m);
                    #1;
                    ready_clr = 1'b0;
                end else begin
                    repeat (10) wait_tick();
                end
                rx = 1'b1;
                sb_check(name);
                repeat (6) wait_tick();
            end else begin
                repeat (c_os) wait_tick();
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{payload: 8'hA5, bad_stop: -1, exp: mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[1] = '{payload: 8'h80, bad_stop:  0, exp: mk(8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[2] = '{payload: 8'hFF, bad_stop: -1, exp: mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};

        repeat (3) @(negedge clk_50m);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            check_rec("reset_state", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        sel  = 0;
        rstn = 1'b1;
        repeat (2) wait_tick();

        // Basic frames, clear after each; error flags survive the clear
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(vecs[i].exp);
            send_frame("table_frame", vecs[i].payload, 1'b0, 1'b0, 1, vecs[i].bad_stop, -1, 1'b0);
            pulse_clr();
            check_bit("table_clr_ready", rdy[0], 1'b0);
            check_bit("table_clr_overrun", ovr[0], 1'b0);
            check_bit("table_ferr_held", ferr[0], vecs[i].exp.ferr);
        end

        // Overrun, then clear, then clear coinciding with completion
        sb_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("ovr_first", 8'h3C, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        sb_q.push_back(mk(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        send_frame("ovr_second", 8'h81, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        pulse_clr();
        check_bit("ovr_clr_ready", rdy[0], 1'b0);
        check_bit("ovr_clr_overrun", ovr[0], 1'b0);
        sb_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("clrwin_first", 8'h3C, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        sb_q.push_back(mk(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("clrwin_second", 8'h81, 1'b0, 1'b0, 1, -1, -1, 1'b1);

        // Reset during data bit 4 discards the frame and clears outputs at once
        wait_tick();
        rx = 1'b0;
        repeat (c_os) wait_tick();
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (c_os) wait_tick();
        end
        rx = 1'b0;
        repeat (5) wait_tick();
        rstn = 1'b0;
        #1;
        check_rec("rst_mid_frame", mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) @(negedge clk_50m);
        rx   = 1'b1;
        rstn = 1'b1;
        repeat (2) wait_tick();
        sb_q.push_back(mk(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("after_reset", 8'h5A, 1'b0, 1'b0, 1, -1, -1, 1'b0);
        pulse_clr();

        // Short low pulse in idle is a false start
        wait_tick();
        rx = 1'b0;
        repeat (4) wait_tick();
        rx = 1'b1;
        repeat (24) wait_tick();
        check_bit("false_start_ready", rdy[0], 1'b0);

        // One-tick high glitch at the mid sample of data bit 3 is voted out
        sb_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("glitch_vote", 8'h00, 1'b0, 1'b0, 1, -1, 3, 1'b0);
        pulse_clr();

        // Line held low for 12 bit times: break
        sb_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        wait_tick();
        rx = 1'b0;
        repeat (c_os * 9 + 10) wait_tick();
        sb_check("break");
        repeat (c_os * 3 - 10) wait_tick();
        rx = 1'b1;
        reset_all();

        // Even parity instance
        sel = 1;
        sb_q.push_back(mk(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send_frame("parity_ok", 8'h07, 1'b1, 1'b1, 1, -1, -1, 1'b0);
        pulse_clr();
        sb_q.push_back(mk(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        send_frame("parity_bad", 8'h07, 1'b1, 1'b0, 1, -1, -1, 1'b0);

        // Two-stop instance with the second stop bit low
        reset_all();
        sel = 2;
        sb_q.push_back(mk(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        send_frame("stop2_bad", 8'h55, 1'b0, 1'b0, 2, 1, -1, 1'b0);

        check_bit("scoreboard_drained", (sb_q.size() == 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
